fifo_uart_tx: RTL and testbench
===============================

Name: fifo_uart_tx

Overview:
Read-side consumer for the team's synchronous FIFO (sync_fifo / fifo_top). It pops bytes from the FIFO read interface and serialises each one as an asynchronous 8N1 or 8N2 frame on a single TX line. Bit period is runtime-programmable. It is the standard drain path from FIFO-buffered data to an off-chip UART pin.

Parameters:
DATA_WIDTH, 8, bits per frame; must match the FIFO DATA_WIDTH.
DIV_WIDTH, 16, width of the baud_div input.
STOP_BITS, 1, number of stop bits; legal values are 1 or 2.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
enable  input  1  permits new frames to start; a frame in progress always completes.
baud_div  input  DIV_WIDTH  bit period = baud_div+1 clk cycles.
fifo_rd_data  input  DATA_WIDTH  FIFO read data; valid the cycle after fifo_rd_en is asserted with fifo_empty=0.
fifo_empty  input  1  FIFO empty flag.
fifo_rd_en  output  1  single-cycle pop request to the FIFO.
tx  output  1  serial line; idles high.
busy  output  1  high from the pop cycle through the last stop-bit cycle.

Behaviour:
- Clock and reset: single clock domain, clk. rst_n is asynchronous, active-low.
- Reset values: state=IDLE, tx=1, busy=0, fifo_rd_en=0, all counters 0, shift register 0. Reset takes effect immediately, including mid-frame: tx returns high at once and the partially sent byte is lost (not re-queued).
- State machine: IDLE -> FETCH -> START -> DATA -> STOP -> IDLE.
- IDLE:
  - fifo_rd_en = enable & ~fifo_empty (combinational, from state IDLE only).
  - If the pop is issued, go to FETCH next cycle; otherwise stay in IDLE.
  - tx=1, busy=0.
- FETCH (1 cycle):
  - Capture fifo_rd_data into the shift register.
  - Latch baud_div into div_q; div_q is used for the whole frame, so baud_div changes mid-frame have no effect.
  - busy=1, tx=1. Go to START.
- START: tx=0 for div_q+1 cycles, then go to DATA.
- DATA:
  - Send DATA_WIDTH bits LSB first, each for div_q+1 cycles.
  - Shift register shifts right at each bit boundary; bit counter runs 0..DATA_WIDTH-1.
  - After the last bit, go to STOP.
- STOP:
  - tx=1 for STOP_BITS*(div_q+1) cycles, then go to IDLE.
  - busy drops in the IDLE cycle that follows.
- Frame length: (1 + DATA_WIDTH + STOP_BITS)*(div_q+1) cycles of tx activity.
- Pop-to-first-edge latency: the start bit begins 2 cycles after the fifo_rd_en cycle (pop cycle, then FETCH).
- Back-to-back frames: minimum tx-high gap between frames = STOP_BITS*(div_q+1) + 2 cycles (one IDLE cycle plus FETCH).
- fifo_rd_en constraints:
  - Never asserted outside IDLE.
  - Never asserted while fifo_empty=1.
  - At most one pulse per frame.
- enable:
  - Sampled only in IDLE.
  - Deassertion mid-frame does not truncate the frame.
  - After the frame, the block stays in IDLE with no further pops.
- baud_div=0: 1 cycle per bit, which is legal; no special case.
- Bit-period counter: DIV_WIDTH bits, counts 0..div_q, wraps to 0 at each bit boundary. No overflow is possible because div_q ≤ 2^DIV_WIDTH-1.
- Simultaneous fifo_empty rising in the pop cycle: the pop was already accepted by the FIFO, so data is taken in FETCH regardless.

Decomposition:
- Package fifo_uart_pkg:
  - State enum typedef: IDLE, FETCH, START, DATA, STOP (3-bit).
  - localparam FRAME_BITS = 1 + DATA_WIDTH + STOP_BITS for the bench.
- One sub-module: uart_baud_tick.
  - Loadable DIV_WIDTH down-counter.
  - Inputs: clear, div.
  - Output: tick, asserted on the last cycle of each bit period.
  - Also reusable by a future uart_rx → FIFO write-side block.

Test Plan:
- Single byte: FIFO holds 0xA5, baud_div=3, enable=1.
  - One fifo_rd_en pulse.
  - 2 cycles later tx = 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles (40 cycles total).
  - busy high for 42 cycles.
- Back-to-back: 0x00 then 0xFF, baud_div=0, STOP_BITS=1.
  - Two pops.
  - Frames of 10 cycles each, separated by exactly 3 tx-high cycles (1 stop + 2).
  - Data bits are all-0 then all-1.
- Empty/enable:
  - fifo_empty=1 for 50 cycles -> fifo_rd_en never asserts, tx=1, busy=0.
  - enable=0 with the FIFO non-empty -> no pop.
  - Dropping enable mid-frame -> frame completes and no next pop occurs.
- baud_div change mid-frame: change 3->7 during the DATA state.
  - Current frame keeps 4-cycle bits.
  - Next frame uses 8-cycle bits.
- Reset mid-frame: assert rst_n=0 during DATA bit 3.
  - tx=1, busy=0, fifo_rd_en=0 in the same cycle (async).
  - After release, the next FIFO byte is sent as a clean frame.
- STOP_BITS=2, baud_div=1, byte 0x3C: stop interval = 4 cycles high; total frame = 22 cycles.

Source files
------------

// File: rtl/fifo_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fifo_uart_pkg
// Brief   : Shared state encoding and frame constants for fifo_uart_tx.
// Revision: 1.0 - initial release
// ============================================================================
package fifo_uart_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_STOP_BITS  = 1;
    localparam int FRAME_BITS     = 1 + DEF_DATA_WIDTH + DEF_STOP_BITS;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4
    } state_t;

    // Clock cycles of line activity for one frame at a given divider.
    function automatic int frame_cycles(input int data_width, input int stop_bits,
                                        input int div);
        return (1 + data_width + stop_bits) * (div + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_uart_tx_baud_tick.sv
`default_nettype none
// ============================================================================
// Module  : uart_baud_tick
// Brief   : Loadable down-counter; tick marks the last cycle of each bit period.
// Revision: 1.0 - initial release
// ============================================================================
module uart_baud_tick #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] r_cnt;

    // Reload on clear and on every terminal count so each period is div+1 cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clear || (r_cnt == '0)) begin
            r_cnt <= div;
        end else begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign tick = ~clear & (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module  : fifo_uart_tx
// Brief   : Pops bytes from a sync FIFO and sends them as 8N1/8N2 UART frames.
// Revision: 1.0 - initial release
// ============================================================================
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [DIV_WIDTH-1:0]  baud_div,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    output logic                  tx,
    output logic                  busy
);

    localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    state_t                r_state;
    logic                  r_tx;
    logic                  r_busy;
    logic [DATA_WIDTH-1:0] r_shreg;
    logic [DIV_WIDTH-1:0]  r_div_q;
    logic [BIT_CNT_W-1:0]  r_bit_cnt;
    logic                  r_stop_cnt;

    logic                  w_pop;
    logic                  w_tick;
    logic                  w_clear;
    logic [DIV_WIDTH-1:0]  w_div;

    // Gated by rst_n so the pop request vanishes the instant reset asserts.
    assign w_pop      = rst_n & (r_state == IDLE) & enable & ~fifo_empty;
    assign fifo_rd_en = w_pop;
    assign busy       = r_busy | w_pop;
    assign tx         = r_tx;

    // The counter is loaded while FETCH latches baud_div, so bypass div_q then.
    assign w_clear = (r_state == IDLE) || (r_state == FETCH);
    assign w_div   = (r_state == FETCH) ? baud_div : r_div_q;

    uart_baud_tick #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_baud_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (w_clear),
        .div   (w_div),
        .tick  (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_shreg    <= '0;
            r_div_q    <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_state <= FETCH;
                        r_busy  <= 1'b1;
                    end
                end
                FETCH: begin
                    r_shreg   <= fifo_rd_data;
                    r_div_q   <= baud_div;
                    r_bit_cnt <= '0;
                    r_tx      <= 1'b0;
                    r_state   <= START;
                end
                START: begin
                    if (w_tick) begin
                        r_tx    <= r_shreg[0];
                        r_shreg <= r_shreg >> 1;
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        if (r_bit_cnt == BIT_CNT_W'(DATA_WIDTH - 1)) begin
                            r_tx       <= 1'b1;
                            r_stop_cnt <= 1'b0;
                            r_state    <= STOP;
                        end else begin
                            r_tx      <= r_shreg[0];
                            r_shreg   <= r_shreg >> 1;
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        if (r_stop_cnt == 1'(STOP_BITS - 1)) begin
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            r_stop_cnt <= r_stop_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_fifo_uart_tx
// Brief   : Directed, table-driven bench for fifo_uart_tx (8N1 and 8N2 builds).
// Revision: 1.0 - initial release
// ============================================================================
module tb_fifo_uart_tx;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [15:0] baud_div;
    logic [7:0]  fifo_rd_data;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic        tx;
    logic        busy;

    logic        enable2;
    logic [15:0] baud_div2;
    logic [7:0]  rd_data2;
    logic        empty2;
    logic        rd_en2;
    logic        tx2;
    logic        busy2;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference FIFO: pushes come from the test process, pops from the DUT.
    logic [7:0] mem [0:63];
    int         wr_ptr = 0;
    int         rd_ptr = 0;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_rd_data <= mem[rd_ptr[5:0]];
            rd_ptr       <= rd_ptr + 1;
        end
    end

    fifo_uart_tx #(.DATA_WIDTH(8), .DIV_WIDTH(16), .STOP_BITS(1)) dut1 (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .baud_div     (baud_div),
        .fifo_rd_data (fifo_rd_data),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .tx           (tx),
        .busy         (busy)
    );

    fifo_uart_tx #(.DATA_WIDTH(8), .DIV_WIDTH(16), .STOP_BITS(2)) dut2 (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable2),
        .baud_div     (baud_div2),
        .fifo_rd_data (rd_data2),
        .fifo_empty   (empty2),
        .fifo_rd_en   (rd_en2),
        .tx           (tx2),
        .busy         (busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [7:0] d);
        mem[wr_ptr[5:0]] = d;
        wr_ptr = wr_ptr + 1;
    endtask

    // Looks for a pop in the current cycle, then in up to 'budget' further cycles.
    task automatic wait_pop(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i <= budget; i++) begin
            #1;
            if (fifo_rd_en === 1'b1) begin
                ok = 1'b1;
                break;
            end
            if (i < budget) @(negedge clk);
        end
    endtask

    // Checks pop, FETCH and every line cycle of one frame; the hook fires once
    // at the first cycle of frame bit 'hook_bit'.
    task automatic run_frame(input logic [10:0] frame, input int nbits, input int div,
                             input int hook_bit, input logic [15:0] hook_div,
                             input bit hook_drop_en, input int budget);
        bit ok;
        wait_pop(budget, ok);
        chk("pop_seen", {31'd0, ok}, 32'd1);
        if (!ok) return;
        chk("busy_at_pop", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("fetch_state", {29'd0, busy, fifo_rd_en, tx}, 32'b101);
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c <= div; c++) begin
                @(negedge clk);
                chk($sformatf("frame_bit%0d", b), {29'd0, busy, fifo_rd_en, tx},
                    {29'd0, 1'b1, 1'b0, frame[b]});
                if (b == hook_bit && c == 0) begin
                    baud_div = hook_div;
                    if (hook_drop_en) enable = 1'b0;
                end
            end
        end
    endtask

    typedef struct {
        logic [7:0]  data;
        logic [15:0] div;
        logic [10:0] frame;     // transmitted order: bit 0 = start bit
        int          hook_bit;
        logic [15:0] hook_div;
        bit          chain;     // queued behind the previous frame
    } vec_t;

    vec_t vecs [6];

    initial begin
        bit ok;

        vecs[0] = '{8'hA5, 16'd3, 11'h34A, -1, 16'd3, 1'b0};
        vecs[1] = '{8'h00, 16'd0, 11'h200, -1, 16'd0, 1'b0};
        vecs[2] = '{8'hFF, 16'd0, 11'h3FE, -1, 16'd0, 1'b1};
        vecs[3] = '{8'h5A, 16'd3, 11'h2B4,  3, 16'd7, 1'b0};
        vecs[4] = '{8'h81, 16'd7, 11'h302, -1, 16'd7, 1'b1};
        vecs[5] = '{8'h5A, 16'd2, 11'h2B4, -1, 16'd2, 1'b0};

        rst_n     = 1'b0;
        enable    = 1'b0;
        baud_div  = 16'd3;
        enable2   = 1'b0;
        baud_div2 = 16'd1;
        rd_data2  = 8'h3C;
        empty2    = 1'b1;

        repeat (3) @(negedge clk);
        chk("reset_dut1", {29'd0, busy, fifo_rd_en, tx}, 32'b001);
        chk("reset_dut2", {29'd0, busy2, rd_en2, tx2}, 32'b001);
        rst_n = 1'b1;

        // Empty FIFO with enable high: the line must stay idle.
        enable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("empty_idle", {29'd0, busy, fifo_rd_en, tx}, 32'b001);
        end

        foreach (vecs[i]) begin
            bit next_chain;
            next_chain = (i + 1 < 6) && vecs[i + 1].chain;
            if (!vecs[i].chain) begin
                baud_div = vecs[i].div;
                push(vecs[i].data);
            end
            if (next_chain) push(vecs[i + 1].data);
            run_frame(vecs[i].frame, 10, int'(vecs[i].div), vecs[i].hook_bit,
                      vecs[i].hook_div, 1'b0, vecs[i].chain ? 1 : 200);
            if (!next_chain) begin
                @(negedge clk);
                chk($sformatf("idle_after_vec%0d", i), {29'd0, busy, fifo_rd_en, tx}, 32'b001);
            end
        end

        // enable low with data waiting: no pop.
        enable   = 1'b0;
        baud_div = 16'd1;
        push(8'hC3);
        push(8'h3C);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("disabled_no_pop", {29'd0, busy, fifo_rd_en, tx}, 32'b001);
        end

        // Dropping enable mid-frame: frame completes, no further pop.
        enable = 1'b1;
        run_frame(11'h386, 10, 1, 4, 16'd1, 1'b1, 200);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("dropped_en_no_pop", {29'd0, busy, fifo_rd_en, tx}, 32'b001);
        end
        enable = 1'b1;
        run_frame(11'h278, 10, 1, -1, 16'd1, 1'b0, 200);
        @(negedge clk);
        chk("idle_after_drain", {29'd0, busy, fifo_rd_en, tx}, 32'b001);

        // Reset during DATA bit 3, with another byte still queued.
        baud_div = 16'd3;
        push(8'h96);
        push(8'h69);
        wait_pop(200, ok);
        chk("rst_test_pop", {31'd0, ok}, 32'd1);
        repeat (18) @(negedge clk);
        chk("rst_test_bit3", {29'd0, busy, fifo_rd_en, tx}, 32'b100);
        rst_n = 1'b0;
        #1;
        chk("async_reset", {29'd0, busy, fifo_rd_en, tx}, 32'b001);
        @(negedge clk);
        chk("held_reset", {29'd0, busy, fifo_rd_en, tx}, 32'b001);
        rst_n = 1'b1;
        run_frame(11'h2D2, 10, 3, -1, 16'd3, 1'b0, 200);
        @(negedge clk);
        chk("idle_after_reset_frame", {29'd0, busy, fifo_rd_en, tx}, 32'b001);
        enable = 1'b0;

        // Two stop bits, baud_div=1, byte 0x3C: 22-cycle frame.
        empty2  = 1'b0;
        enable2 = 1'b1;
        #1;
        chk("dut2_pop", {30'd0, busy2, rd_en2}, 32'b11);
        @(negedge clk);
        empty2 = 1'b1;
        chk("dut2_fetch", {29'd0, busy2, rd_en2, tx2}, 32'b101);
        begin
            logic [10:0] f2;
            f2 = 11'h678;
            for (int b = 0; b < 11; b++) begin
                for (int c = 0; c < 2; c++) begin
                    @(negedge clk);
                    chk($sformatf("dut2_bit%0d", b), {29'd0, busy2, rd_en2, tx2},
                        {29'd0, 1'b1, 1'b0, f2[b]});
                end
            end
        end
        @(negedge clk);
        chk("dut2_idle", {29'd0, busy2, rd_en2, tx2}, 32'b001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
